// File: rtl/accum_scheduler.sv
// accum_scheduler: round-robin DTP result arbiter feeding the accumulator
// input FIFOs, with collect/drain/finish sequencing and flush on abort.
module accum_scheduler #(
    parameter int N_DTPS       = 4,
    parameter int FIFO_WIDTH   = 16,
    parameter int TREE_CNT_W   = 8,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_start,
    input  logic [TREE_CNT_W-1:0]        i_n_trees,
    input  logic                         i_is_clf,
    input  logic                         i_abort,
    output logic                         o_busy,
    output logic                         o_done,
    input  logic [N_DTPS-1:0]            i_dtp_vld,
    input  logic [N_DTPS*FIFO_WIDTH-1:0] i_dtp_data,
    output logic [N_DTPS-1:0]            o_dtp_rdy,
    output logic [N_DTPS-1:0]            o_in_fifo_push,
    output logic [N_DTPS*FIFO_WIDTH-1:0] o_in_fifo_rear,
    input  logic [N_DTPS-1:0]            i_in_fifo_is_full,
    output logic                         o_is_clf,
    output logic                         o_is_accum_fin,
    output logic                         o_flush
);

    localparam int PW = (N_DTPS > 1) ? $clog2(N_DTPS) : 1;
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [TREE_CNT_W-1:0] CNT_ONE = TREE_CNT_W'(1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_DRAIN,
        S_FIN,
        S_FLUSH
    } state_t;

    state_t                         state_q, state_d;
    logic [TREE_CNT_W-1:0]          n_trees_q, cnt_q;
    logic [DW-1:0]                  drain_q;
    logic [PW-1:0]                  ptr_q, ptr_d;
    logic [N_DTPS-1:0]              push_q, gnt, elig;
    logic [N_DTPS*FIFO_WIDTH-1:0]   rear_q, rear_d;
    logic                           is_clf_q, start_ok, gnt_any, last_gnt;

    // An accepted start needs IDLE and no competing abort.
    assign start_ok = (state_q == S_IDLE) && i_start && !i_abort;
    // A push already in flight occupies a FIFO slot not yet seen in full.
    assign elig = i_dtp_vld & ~i_in_fifo_is_full & ~push_q;
    assign last_gnt = gnt_any && ((cnt_q + CNT_ONE) == n_trees_q);

    // Round-robin search from the pointer; no grant while aborting.
    always_comb begin
        int j;
        j       = 0;
        gnt     = '0;
        gnt_any = 1'b0;
        ptr_d   = ptr_q;
        rear_d  = '0;
        if (state_q == S_COLLECT && !i_abort) begin
            for (int k = 0; k < N_DTPS; k++) begin
                j = (int'(ptr_q) + k) % N_DTPS;
                if (!gnt_any && elig[j]) begin
                    gnt_any = 1'b1;
                    gnt[j]  = 1'b1;
                    ptr_d   = PW'((j + 1) % N_DTPS);
                    rear_d[j*FIFO_WIDTH +: FIFO_WIDTH] =
                        i_dtp_data[j*FIFO_WIDTH +: FIFO_WIDTH];
                end
            end
        end
    end

    // Sequencer next state; abort overrides everything.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_abort) begin
                    state_d = S_FLUSH;
                end else if (i_start) begin
                    state_d = (i_n_trees == '0) ? S_FIN : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (i_abort) begin
                    state_d = S_FLUSH;
                end else if (last_gnt) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (i_abort) begin
                    state_d = S_FLUSH;
                end else if (drain_q == DRAIN_LAST) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = i_abort ? S_FLUSH : S_IDLE;
            end
            S_FLUSH: begin
                state_d = i_abort ? S_FLUSH : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Push/data registers, pointer, counters and latched sample config.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_q    <= '0;
            rear_q    <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            n_trees_q <= '0;
            is_clf_q  <= 1'b0;
            drain_q   <= '0;
        end else begin
            push_q <= gnt;
            rear_q <= rear_d;
            ptr_q  <= ptr_d;
            if (start_ok) begin
                n_trees_q <= i_n_trees;
                is_clf_q  <= i_is_clf;
                cnt_q     <= '0;
            end else if (gnt_any) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
            if (state_q == S_DRAIN) begin
                drain_q <= drain_q + DW'(1);
            end else begin
                drain_q <= '0;
            end
        end
    end

    assign o_dtp_rdy      = gnt;
    assign o_in_fifo_push = push_q;
    assign o_in_fifo_rear = rear_q;
    assign o_is_clf       = is_clf_q;
    assign o_busy         = (state_q != S_IDLE);
    assign o_done         = (state_q == S_FIN);
    assign o_is_accum_fin = (state_q == S_FIN);
    assign o_flush        = (state_q == S_FLUSH);

endmodule

// File: tb/tb_accum_scheduler.sv
// tb_accum_scheduler: directed stimulus with a scoreboard of expected
// pushes, finish and flush events checked by an independent monitor.
module tb_accum_scheduler;

    localparam int N = 4;
    localparam int W = 16;
    localparam int K_PUSH = 0;
    localparam int K_FIN = 1;
    localparam int K_FLUSH = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           i_start = 1'b0;
    logic [7:0]     i_n_trees = '0;
    logic           i_is_clf = 1'b0;
    logic           i_abort = 1'b0;
    logic           o_busy, o_done;
    logic [N-1:0]   i_dtp_vld = '0;
    logic [N*W-1:0] i_dtp_data = '0;
    logic [N-1:0]   o_dtp_rdy, o_in_fifo_push;
    logic [N*W-1:0] o_in_fifo_rear;
    logic [N-1:0]   i_in_fifo_is_full = '0;
    logic           o_is_clf, o_is_accum_fin, o_flush;

    typedef struct {
        int kind;
        int idx;
        int cyc;
    } exp_t;

    exp_t         sb[$];
    int           cyc = 0;
    int           n_pass = 0;
    int           n_total = 0;
    logic [N-1:0] prev_push = '0;

    accum_scheduler dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_start(i_start),
        .i_n_trees(i_n_trees),
        .i_is_clf(i_is_clf),
        .i_abort(i_abort),
        .o_busy(o_busy),
        .o_done(o_done),
        .i_dtp_vld(i_dtp_vld),
        .i_dtp_data(i_dtp_data),
        .o_dtp_rdy(o_dtp_rdy),
        .o_in_fifo_push(o_in_fifo_push),
        .o_in_fifo_rear(o_in_fifo_rear),
        .i_in_fifo_is_full(i_in_fifo_is_full),
        .o_is_clf(o_is_clf),
        .o_is_accum_fin(o_is_accum_fin),
        .o_flush(o_flush)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] dat(input int i);
        return 16'hC3A5 ^ 16'(i * 16'h1111);
    endfunction

    function automatic logic [N*W-1:0] rear_of(input int i);
        logic [N*W-1:0] r;
        r = '0;
        r[i*W +: W] = dat(i);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic at_cyc(input int t);
        @(negedge clk);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic exp_ev(input int kind, input int idx, input int c);
        exp_t e;
        e.kind = kind;
        e.idx = idx;
        e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic start(input int n, input logic clf, input logic [N-1:0] vld,
                         input logic [N-1:0] full, input logic abt,
                         output int c0);
        next_edge();
        c0 = cyc;
        i_start = 1'b1;
        i_n_trees = 8'(n);
        i_is_clf = clf;
        i_dtp_vld = vld;
        i_in_fifo_is_full = full;
        i_abort = abt;
    endtask

    // Monitor: pops an expectation whenever the DUT presents an event.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (|o_in_fifo_push) begin
                if (sb.size() == 0) begin
                    chk("push_unexpected", 64'(o_in_fifo_push), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("push_kind", 64'(K_PUSH), 64'(e.kind));
                    chk("push_onehot", 64'(o_in_fifo_push), 64'(1 << e.idx));
                    chk("push_rear", o_in_fifo_rear, rear_of(e.idx));
                    if (e.cyc >= 0) chk("push_cyc", 64'(cyc), 64'(e.cyc));
                end
                chk("no_back2back", 64'(o_in_fifo_push & prev_push), 64'd0);
            end
            if (o_is_accum_fin) begin
                if (sb.size() == 0) begin
                    chk("fin_unexpected", 64'(o_is_accum_fin), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("fin_kind", 64'(K_FIN), 64'(e.kind));
                    chk("fin_done", 64'(o_done), 64'd1);
                    if (e.cyc >= 0) chk("fin_cyc", 64'(cyc), 64'(e.cyc));
                end
            end else if (o_done) begin
                chk("done_without_fin", 64'(o_done), 64'd0);
            end
            if (o_flush) begin
                if (sb.size() == 0) begin
                    chk("flush_unexpected", 64'(o_flush), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("flush_kind", 64'(K_FLUSH), 64'(e.kind));
                    if (e.cyc >= 0) chk("flush_cyc", 64'(cyc), 64'(e.cyc));
                end
            end
            prev_push = o_in_fifo_push;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        for (int i = 0; i < N; i++) i_dtp_data[i*W +: W] = dat(i);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_push", 64'(o_in_fifo_push), 64'd0);
        chk("rst_rear", o_in_fifo_rear, 64'd0);
        chk("rst_clf", 64'(o_is_clf), 64'd0);
        chk("rst_fin", 64'(o_is_accum_fin | o_done | o_flush), 64'd0);
        chk("rst_rdy", 64'(o_dtp_rdy), 64'd0);

        // Basic collect: 8 trees, all DTPs valid.
        start(8, 1'b1, 4'b1111, 4'b0000, 1'b0, c0);
        for (int k = 0; k < 8; k++) exp_ev(K_PUSH, k % 4, c0 + 2 + k);
        exp_ev(K_FIN, 0, c0 + 13);
        next_edge();
        i_start = 1'b0;
        at_cyc(c0 + 14);
        chk("t1_idle", 64'(o_busy), 64'd0);
        chk("t1_clf", 64'(o_is_clf), 64'd1);

        // Move pointer to 2.
        start(2, 1'b0, 4'b1111, 4'b0000, 1'b0, c0);
        exp_ev(K_PUSH, 0, c0 + 2);
        exp_ev(K_PUSH, 1, c0 + 3);
        exp_ev(K_FIN, 0, c0 + 7);
        next_edge();
        i_start = 1'b0;
        at_cyc(c0 + 8);
        chk("t2a_idle", 64'(o_busy), 64'd0);
        chk("t2a_clf", 64'(o_is_clf), 64'd0);

        // Fairness and wrap: DTP1 and DTP3 only.
        start(4, 1'b1, 4'b1010, 4'b0000, 1'b0, c0);
        exp_ev(K_PUSH, 3, c0 + 2);
        exp_ev(K_PUSH, 1, c0 + 3);
        exp_ev(K_PUSH, 3, c0 + 4);
        exp_ev(K_PUSH, 1, c0 + 5);
        exp_ev(K_FIN, 0, c0 + 9);
        next_edge();
        i_start = 1'b0;
        at_cyc(c0 + 10);
        chk("t2_idle", 64'(o_busy), 64'd0);

        // Backpressure on DTP0, then release.
        start(2, 1'b0, 4'b0001, 4'b0001, 1'b0, c0);
        exp_ev(K_PUSH, 0, c0 + 5);
        exp_ev(K_PUSH, 0, c0 + 7);
        exp_ev(K_FIN, 0, c0 + 11);
        next_edge();
        i_start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            at_cyc(c0 + k);
            chk("t3_full_rdy", 64'(o_dtp_rdy), 64'd0);
        end
        next_edge();
        i_in_fifo_is_full = '0;
        at_cyc(c0 + 4);
        chk("t3_resume_rdy", 64'(o_dtp_rdy), 64'b0001);
        at_cyc(c0 + 5);
        chk("t3_inflight_rdy", 64'(o_dtp_rdy), 64'd0);
        at_cyc(c0 + 12);
        chk("t3_idle", 64'(o_busy), 64'd0);

        // Exact count: 3 trees, no over-accept.
        start(3, 1'b1, 4'b1111, 4'b0000, 1'b0, c0);
        exp_ev(K_PUSH, 1, c0 + 2);
        exp_ev(K_PUSH, 2, c0 + 3);
        exp_ev(K_PUSH, 3, c0 + 4);
        exp_ev(K_FIN, 0, c0 + 8);
        next_edge();
        i_start = 1'b0;
        at_cyc(c0 + 3);
        chk("t4_third_rdy", 64'(o_dtp_rdy), 64'b1000);
        at_cyc(c0 + 4);
        chk("t4_drain_rdy", 64'(o_dtp_rdy), 64'd0);
        at_cyc(c0 + 9);
        chk("t4_idle", 64'(o_busy), 64'd0);

        // Zero trees.
        start(0, 1'b0, 4'b1111, 4'b0000, 1'b0, c0);
        exp_ev(K_FIN, 0, c0 + 1);
        next_edge();
        i_start = 1'b0;
        at_cyc(c0 + 1);
        chk("t5_rdy", 64'(o_dtp_rdy), 64'd0);
        at_cyc(c0 + 2);
        chk("t5_idle", 64'(o_busy), 64'd0);

        // Abort on the second push of a 6-tree sample.
        start(6, 1'b0, 4'b1111, 4'b0000, 1'b0, c0);
        exp_ev(K_PUSH, 0, c0 + 2);
        exp_ev(K_PUSH, 1, c0 + 3);
        exp_ev(K_FLUSH, 0, c0 + 4);
        next_edge();
        i_start = 1'b0;
        next_edge();
        next_edge();
        i_abort = 1'b1;
        at_cyc(c0 + 3);
        chk("t6_abort_rdy", 64'(o_dtp_rdy), 64'd0);
        next_edge();
        i_abort = 1'b0;
        at_cyc(c0 + 4);
        chk("t6_flush_busy", 64'(o_busy), 64'd1);
        at_cyc(c0 + 5);
        chk("t6_idle", 64'(o_busy), 64'd0);

        // Start and abort together in IDLE: abort wins.
        start(5, 1'b1, 4'b1111, 4'b0000, 1'b1, c0);
        exp_ev(K_FLUSH, 0, c0 + 1);
        next_edge();
        i_start = 1'b0;
        i_abort = 1'b0;
        at_cyc(c0 + 1);
        chk("t7_flush_busy", 64'(o_busy), 64'd1);
        at_cyc(c0 + 2);
        chk("t7_idle", 64'(o_busy), 64'd0);
        chk("t7_clf_kept", 64'(o_is_clf), 64'd0);

        // Abort during the FIN cycle.
        start(0, 1'b1, 4'b0000, 4'b0000, 1'b0, c0);
        exp_ev(K_FIN, 0, c0 + 1);
        exp_ev(K_FLUSH, 0, c0 + 2);
        next_edge();
        i_start = 1'b0;
        i_abort = 1'b1;
        next_edge();
        i_abort = 1'b0;
        at_cyc(c0 + 3);
        chk("t8_idle", 64'(o_busy), 64'd0);
        chk("t8_clf", 64'(o_is_clf), 64'd1);

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
